// File: rtl/ula_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states and
// iteration count.
package ula_pkg;

  localparam logic [4:0] ULA_AND      = 5'b00000;
  localparam logic [4:0] ULA_OR       = 5'b00001;
  localparam logic [4:0] ULA_ADD      = 5'b00010;
  localparam logic [4:0] ULA_SRL      = 5'b00011;
  localparam logic [4:0] ULA_MUL      = 5'b00100;
  localparam logic [4:0] ULA_DIV      = 5'b00101;
  localparam logic [4:0] ULA_SUB      = 5'b00110;
  localparam logic [4:0] ULA_SLT      = 5'b00111;
  localparam logic [4:0] ULA_LUI      = 5'b01000;
  localparam logic [4:0] ULA_REM      = 5'b01001;
  localparam logic [4:0] ULA_SGT      = 5'b01010;
  localparam logic [4:0] ULA_SGTE     = 5'b01011;
  localparam logic [4:0] ULA_NOT      = 5'b01100;
  localparam logic [4:0] ULA_SEQ      = 5'b01101;
  localparam logic [4:0] ULA_SLL      = 5'b01110;
  localparam logic [4:0] ULA_SNEQ     = 5'b01111;
  localparam logic [4:0] ULA_SLTE     = 5'b10000;
  localparam logic [4:0] ULA_INVALIDO = 5'b11111;

  localparam int ITERACOES = 32;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} ula_estado_t;

endpackage

// File: rtl/ula_divisor.sv
// Iterative signed divider: restoring division on magnitudes over LARGURA
// cycles, then one sign fix-up cycle where done is asserted.
//
// state | meaning
// IDLE  | waiting for start, operands loaded on start
// DIV   | one restoring step per cycle, down-counter to zero
// FIX   | signs applied to quotient/remainder, done high
module ula_divisor
  import ula_pkg::*;
#(
  parameter int LARGURA = ITERACOES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [LARGURA-1:0] dividendo,
  input  logic [LARGURA-1:0] divisor,
  output logic               done,
  output logic [LARGURA-1:0] quociente,
  output logic [LARGURA-1:0] resto
);

  localparam int CW = $clog2(LARGURA);

  ula_estado_t        estado, estado_prox;
  logic [CW-1:0]      cnt;
  logic [LARGURA-1:0] q, r, d;
  logic               neg_q, neg_r;
  logic [LARGURA:0]   r_sh, tentativa;
  logic               cabe;
  logic               ultima;

  assign ultima    = (cnt == '0);
  assign r_sh      = {r, q[LARGURA-1]};
  assign tentativa = r_sh - {1'b0, d};
  assign cabe      = ~tentativa[LARGURA];

  assign done      = (estado == FIX);
  assign quociente = neg_q ? -q : q;
  assign resto     = neg_r ? -r : r;

  always_comb begin
    estado_prox = estado;
    case (estado)
      IDLE:    if (start) estado_prox = DIV;
      DIV:     if (ultima) estado_prox = FIX;
      FIX:     estado_prox = IDLE;
      default: estado_prox = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= IDLE;
      cnt    <= '0;
      q      <= '0;
      r      <= '0;
      d      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      estado <= estado_prox;
      case (estado)
        IDLE: if (start) begin
          q     <= dividendo[LARGURA-1] ? -dividendo : dividendo;
          d     <= divisor[LARGURA-1] ? -divisor : divisor;
          r     <= '0;
          neg_q <= dividendo[LARGURA-1] ^ divisor[LARGURA-1];
          neg_r <= dividendo[LARGURA-1];
          cnt   <= CW'(LARGURA - 1);
        end
        DIV: begin
          q <= {q[LARGURA-2:0], cabe};
          r <= cabe ? tentativa[LARGURA-1:0] : r_sh[LARGURA-1:0];
          if (!ultima) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/compare/shift datapath, shift-add
// multiplier and an iterative signed divider behind a start/busy/done handshake.
//
// state | meaning
// IDLE  | accepts start; single-cycle codes complete here
// MUL   | shift-add iterations, last one writes the product
// DIV   | divider iterating
// FIX   | divider sign fix-up, result written
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int LARGURA = ITERACOES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         ULActl,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  output logic [LARGURA-1:0] resultado,
  output logic               zero,
  output logic               erro,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(LARGURA);

  ula_estado_t        estado, estado_prox;
  logic [CW-1:0]      cnt;
  logic               ultima;
  logic [4:0]         op;
  logic [LARGURA-1:0] acc, mcand, mplier, parcela;
  logic [LARGURA-1:0] res_simples, res_fim;
  logic               erro_simples, erro_fim, fim;
  logic               div_start, div_done;
  logic [LARGURA-1:0] quociente, resto;

  assign ultima  = (cnt == '0);
  assign parcela = mplier[0] ? mcand : '0;
  assign busy    = (estado != IDLE);

  ula_divisor #(.LARGURA(LARGURA)) u_divisor (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .dividendo (A),
    .divisor   (B),
    .done      (div_done),
    .quociente (quociente),
    .resto     (resto)
  );

  // DIV/REM here only matter when B is zero; otherwise the divider is started
  always_comb begin
    res_simples  = '0;
    erro_simples = 1'b0;
    case (ULActl)
      ULA_AND:  res_simples = A & B;
      ULA_OR:   res_simples = A | B;
      ULA_ADD:  res_simples = A + B;
      ULA_SUB:  res_simples = A - B;
      ULA_SLT:  res_simples = LARGURA'($signed(A) <  $signed(B));
      ULA_SGT:  res_simples = LARGURA'($signed(A) >  $signed(B));
      ULA_SGTE: res_simples = LARGURA'($signed(A) >= $signed(B));
      ULA_SLTE: res_simples = LARGURA'($signed(A) <= $signed(B));
      ULA_SEQ:  res_simples = LARGURA'(A == B);
      ULA_SNEQ: res_simples = LARGURA'(A != B);
      ULA_SRL:  res_simples = A >> B[4:0];
      ULA_SLL:  res_simples = A << B[4:0];
      ULA_LUI:  res_simples = B << 16;
      ULA_NOT:  res_simples = ~A;
      ULA_MUL:  res_simples = '0;
      ULA_DIV: begin
        res_simples  = '1;
        erro_simples = 1'b1;
      end
      ULA_REM: begin
        res_simples  = A;
        erro_simples = 1'b1;
      end
      default:  erro_simples = 1'b1;
    endcase
  end

  always_comb begin
    estado_prox = estado;
    div_start   = 1'b0;
    fim         = 1'b0;
    res_fim     = '0;
    erro_fim    = 1'b0;
    case (estado)
      IDLE: if (start) begin
        if (ULActl == ULA_MUL) begin
          estado_prox = MUL;
        end else if ((ULActl == ULA_DIV || ULActl == ULA_REM) && B != '0) begin
          estado_prox = DIV;
          div_start   = 1'b1;
        end else begin
          fim      = 1'b1;
          res_fim  = res_simples;
          erro_fim = erro_simples;
        end
      end
      MUL: if (ultima) begin
        estado_prox = IDLE;
        fim         = 1'b1;
        res_fim     = acc + parcela;
      end
      DIV: if (ultima) estado_prox = FIX;
      FIX: if (div_done) begin
        estado_prox = IDLE;
        fim         = 1'b1;
        res_fim     = (op == ULA_REM) ? resto : quociente;
      end
      default: estado_prox = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= IDLE;
      cnt       <= '0;
      op        <= ULA_AND;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      resultado <= '0;
      zero      <= 1'b1;
      erro      <= 1'b0;
      done      <= 1'b0;
    end else begin
      estado <= estado_prox;
      done   <= fim;
      if (fim) begin
        resultado <= res_fim;
        zero      <= (res_fim == '0);
        erro      <= erro_fim;
      end
      case (estado)
        IDLE: if (start) begin
          cnt    <= CW'(LARGURA - 1);
          op     <= ULActl;
          acc    <= '0;
          mcand  <= A;
          mplier <= B;
        end
        MUL: begin
          acc    <= acc + parcela;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (!ultima) cnt <= cnt - 1'b1;
        end
        DIV: if (!ultima) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_ula_multiciclo;
  import ula_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [4:0]  ULActl;
  logic [31:0] A, B;
  logic [31:0] resultado;
  logic        zero, erro, busy, done;

  int testes = 0;
  int falhas = 0;

  ula_multiciclo #(.LARGURA(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .ULActl    (ULActl),
    .A         (A),
    .B         (B),
    .resultado (resultado),
    .zero      (zero),
    .erro      (erro),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    testes++;
    if (obs !== esp) begin
      falhas++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, esp);
    end
  endtask

  function automatic void modelo(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e, output int lat);
    longint sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = 32'h0;
    e   = 1'b0;
    lat = 0;
    case (op)
      ULA_AND:  r = a & b;
      ULA_OR:   r = a | b;
      ULA_ADD:  r = a + b;
      ULA_SUB:  r = a - b;
      ULA_SLT:  r = (sa <  sb) ? 32'd1 : 32'd0;
      ULA_SGT:  r = (sa >  sb) ? 32'd1 : 32'd0;
      ULA_SGTE: r = (sa >= sb) ? 32'd1 : 32'd0;
      ULA_SLTE: r = (sa <= sb) ? 32'd1 : 32'd0;
      ULA_SEQ:  r = (a == b) ? 32'd1 : 32'd0;
      ULA_SNEQ: r = (a != b) ? 32'd1 : 32'd0;
      ULA_SRL:  r = a >> b[4:0];
      ULA_SLL:  r = a << b[4:0];
      ULA_LUI:  r = b << 16;
      ULA_NOT:  r = ~a;
      ULA_MUL: begin
        r   = 32'(longint'(a) * longint'(b));
        lat = 32;
      end
      ULA_DIV: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; e = 1'b1; end
        else begin r = 32'(sa / sb); lat = 33; end
      end
      ULA_REM: begin
        if (b == 0) begin r = a; e = 1'b1; end
        else begin r = 32'(sa % sb); lat = 33; end
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic operar(input string nome, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit interferir);
    logic [31:0] r_esp;
    logic        e_esp;
    int          lat_esp, n, n_busy;
    modelo(op, a, b, r_esp, e_esp, lat_esp);
    @(negedge clock);
    start = 1'b1; ULActl = op; A = a; B = b;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0; n_busy = 0;
    while (!done && n < 40) begin
      if (busy) n_busy++;
      @(posedge clock); #1;
      n++;
      if (interferir && n == 10) begin
        start = 1'b1; ULActl = ULA_ADD; A = 32'h1; B = 32'h1;
      end else if (interferir && n == 11) begin
        start = 1'b0;
      end
    end
    checar({nome, ".latencia"}, 32'(n), 32'(lat_esp));
    checar({nome, ".ciclos_busy"}, 32'(n_busy), 32'(lat_esp));
    checar({nome, ".resultado"}, resultado, r_esp);
    checar({nome, ".zero"}, {31'b0, zero}, {31'b0, r_esp == 32'h0});
    checar({nome, ".erro"}, {31'b0, erro}, {31'b0, e_esp});
    checar({nome, ".busy_fim"}, {31'b0, busy}, 32'h0);
    @(posedge clock); #1;
    checar({nome, ".done_pulso"}, {31'b0, done}, 32'h0);
  endtask

  logic [4:0] codigos [18] = '{ULA_AND, ULA_OR, ULA_ADD, ULA_SRL, ULA_MUL, ULA_DIV,
                               ULA_SUB, ULA_SLT, ULA_LUI, ULA_REM, ULA_SGT, ULA_SGTE,
                               ULA_NOT, ULA_SEQ, ULA_SLL, ULA_SNEQ, ULA_SLTE, ULA_INVALIDO};

  initial begin
    int n_done;
    logic [4:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; start = 1'b0; ULActl = 5'b0; A = 32'h0; B = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    checar("reset.resultado", resultado, 32'h0);
    checar("reset.zero", {31'b0, zero}, 32'h1);
    checar("reset.erro", {31'b0, erro}, 32'h0);
    checar("reset.busy", {31'b0, busy}, 32'h0);
    checar("reset.done", {31'b0, done}, 32'h0);
    reset = 1'b0;

    operar("add_ovf", ULA_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0);
    operar("sub_zero", ULA_SUB, 32'd5, 32'd5, 1'b0);
    operar("slt_neg", ULA_SLT, 32'hFFFF_FFFF, 32'h1, 1'b0);
    operar("sgte_eq", ULA_SGTE, 32'd3, 32'd3, 1'b0);
    operar("sll_31", ULA_SLL, 32'h1, 32'd31, 1'b0);
    operar("srl_mask", ULA_SRL, 32'h8000_0000, 32'h24, 1'b0);
    operar("mul_neg", ULA_MUL, 32'hFFFF_FFFD, 32'd7, 1'b1);
    operar("div_neg", ULA_DIV, -32'sd7, 32'd2, 1'b0);
    operar("rem_neg", ULA_REM, -32'sd7, 32'd2, 1'b0);
    operar("div_min", ULA_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    operar("rem_min", ULA_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    operar("div_por_zero", ULA_DIV, 32'd9, 32'd0, 1'b0);
    operar("invalido", ULA_INVALIDO, 32'h1234, 32'h5678, 1'b0);
    operar("and_valido", ULA_AND, 32'hF0, 32'h3C, 1'b0);
    operar("rem_por_zero", ULA_REM, 32'd9, 32'd0, 1'b0);

    @(negedge clock);
    start = 1'b1; ULActl = ULA_MUL; A = 32'd123; B = 32'd456;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checar("rst_mul.resultado", resultado, 32'h0);
    checar("rst_mul.zero", {31'b0, zero}, 32'h1);
    checar("rst_mul.erro", {31'b0, erro}, 32'h0);
    checar("rst_mul.busy", {31'b0, busy}, 32'h0);
    n_done = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) n_done++;
    end
    checar("rst_mul.sem_done", 32'(n_done), 32'h0);
    operar("add_pos_reset", ULA_ADD, 32'd10, 32'd20, 1'b0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
      else op = codigos[$urandom_range(0, 17)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = 32'($urandom_range(0, 40));
        2: b = -32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      operar("aleatorio", op, a, b, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
